// File: rtl/loader_pkg.sv
// Shared types and widths for the program loader (state set depends on LOADER_CHECKSUM_EN).
package loader_pkg;

  localparam int unsigned NIBS_PER_WORD = 4;
  localparam int unsigned ADDR_W        = 4;
  localparam int unsigned NIB_W         = 4;
  localparam int unsigned WORD_W        = NIB_W * NIBS_PER_WORD;
  localparam int unsigned CNT_W         = 2;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/nib_shift.sv
// Nibble assembly register: shifts nibbles in MSN-first and flags the 4th nibble of a word.
module nib_shift
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_shift,
  input  logic [NIB_W-1:0]  i_nib,
  output logic              o_word_full_c,
  output logic [WORD_W-1:0] o_word_c
);

  logic [WORD_W-1:0] r_word;
  logic [CNT_W-1:0]  r_cnt;

  // Word as it will look once the current nibble is shifted in.
  assign o_word_c      = {r_word[WORD_W-NIB_W-1:0], i_nib};
  assign o_word_full_c = i_shift && (r_cnt == CNT_W'(NIBS_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_word <= o_word_c;
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads NUM_WORDS nibble-streamed instructions into memory while holding the CPU.
// Optional checksum word verification enabled by LOADER_CHECKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [NIB_W-1:0]  RX_NIB,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [WORD_W-1:0] WR_DATA,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rx_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [WORD_W-1:0] r_wr_data;
  logic              r_cpu_hold;
  logic              r_done;

  logic              w_idle_like;
  logic              w_clr;
  logic              w_shift;
  logic              w_full;
  logic [WORD_W-1:0] w_word;

`ifdef LOADER_CHECKSUM_EN
  logic              r_err;
  logic [WORD_W-1:0] r_xor;
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
  assign err         = r_err;
`else
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign err         = 1'b0;
`endif

  // Only the resting states honour start; rx_ready gates every nibble transfer.
  assign w_clr   = start && w_idle_like;
  assign w_shift = rx_valid && r_rx_ready;

  nib_shift u_nib_shift (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (w_clr),
    .i_shift       (w_shift),
    .i_nib         (RX_NIB),
    .o_word_full_c (w_full),
    .o_word_c      (w_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_rx_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_err      <= 1'b0;
      r_xor      <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      if (w_clr) begin
        r_state    <= ST_LOAD;
        r_addr     <= '0;
        r_rx_ready <= 1'b1;
        r_cpu_hold <= 1'b1;
        r_done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        r_err      <= 1'b0;
        r_xor      <= '0;
`endif
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (w_full) begin
              r_state    <= ST_WRITE;
              r_rx_ready <= 1'b0;
              r_wr_en    <= 1'b1;
              r_wr_addr  <= r_addr;
              r_wr_data  <= w_word;
            end
          end
          ST_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
            r_xor <= r_xor ^ r_wr_data;
`endif
            if (r_addr == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
              r_state    <= ST_CHECK;
              r_rx_ready <= 1'b1;
`else
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
`endif
            end else begin
              r_state    <= ST_LOAD;
              r_addr     <= r_addr + ADDR_W'(1);
              r_rx_ready <= 1'b1;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          ST_CHECK: begin
            if (w_full) begin
              r_rx_ready <= 1'b0;
              if (w_word == r_xor) begin
                r_state    <= ST_DONE;
                r_done     <= 1'b1;
                r_cpu_hold <= 1'b0;
              end else begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
              end
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  assign rx_ready = r_rx_ready;
  assign wr_en    = r_wr_en;
  assign WR_ADDR  = r_wr_addr;
  assign WR_DATA  = r_wr_data;
  assign cpu_hold = r_cpu_hold;
  assign done     = r_done;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench: two loaders (16 and 2 words) on one stream, checked every cycle against a session model.
module tb_prog_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, rx_valid;
  logic [3:0] RX_NIB;

  logic        o_rdy  [2];
  logic        o_wen  [2];
  logic [3:0]  o_addr [2];
  logic [15:0] o_data [2];
  logic        o_hold [2];
  logic        o_dn   [2];
  logic        o_er   [2];

  always #5 clk = ~clk;

  prog_loader #(.NUM_WORDS(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .RX_NIB(RX_NIB),
    .rx_ready(o_rdy[0]), .wr_en(o_wen[0]), .WR_ADDR(o_addr[0]), .WR_DATA(o_data[0]),
    .cpu_hold(o_hold[0]), .done(o_dn[0]), .err(o_er[0])
  );

  prog_loader #(.NUM_WORDS(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .RX_NIB(RX_NIB),
    .rx_ready(o_rdy[1]), .wr_en(o_wen[1]), .WR_ADDR(o_addr[1]), .WR_DATA(o_data[1]),
    .cpu_hold(o_hold[1]), .done(o_dn[1]), .err(o_er[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Session-level model: what each loader should be showing after every edge.
  int          nw [2] = '{16, 2};
  bit          m_valid = 1'b0;
  bit          m_busy [2], m_recv [2], m_write [2], m_check [2], m_done [2], m_err [2];
  int          m_addr [2], m_cnt [2];
  logic [15:0] m_acc [2], m_xor [2], m_wdata [2];
  logic [3:0]  m_waddr [2];

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_valid = 1'b1;
        m_busy[d] = 0; m_recv[d] = 0; m_write[d] = 0; m_check[d] = 0;
        m_done[d] = 0; m_err[d] = 0; m_addr[d] = 0; m_cnt[d] = 0;
        m_acc[d] = '0; m_xor[d] = '0; m_wdata[d] = '0; m_waddr[d] = '0;
      end else if (m_write[d]) begin
        m_write[d] = 0;
        m_xor[d]   = m_xor[d] ^ m_wdata[d];
        if (m_addr[d] == nw[d] - 1) begin
          if (CK) begin
            m_check[d] = 1; m_recv[d] = 1;
          end else begin
            m_busy[d] = 0; m_done[d] = 1;
          end
        end else begin
          m_addr[d] = m_addr[d] + 1;
          m_recv[d] = 1;
        end
      end else if (m_recv[d]) begin
        if (rx_valid) begin
          m_acc[d] = 16'((m_acc[d] * 16) + RX_NIB);
          m_cnt[d] = m_cnt[d] + 1;
          if (m_cnt[d] == 4) begin
            m_cnt[d]  = 0;
            m_recv[d] = 0;
            if (m_check[d]) begin
              m_check[d] = 0;
              if (m_acc[d] == m_xor[d]) begin
                m_done[d] = 1; m_busy[d] = 0;
              end else begin
                m_err[d] = 1;
              end
            end else begin
              m_write[d] = 1;
              m_waddr[d] = 4'(m_addr[d]);
              m_wdata[d] = m_acc[d];
            end
          end
        end
      end else if (start) begin
        m_busy[d] = 1; m_recv[d] = 1; m_done[d] = 0; m_err[d] = 0;
        m_addr[d] = 0; m_cnt[d] = 0; m_xor[d] = '0; m_acc[d] = '0;
      end
    end
  end

  // Write log captured from the DUT side, used by the literal checks.
  logic [15:0] wmem [2][16];
  int          wcount [2];
  int          wcyc [$];

  always @(negedge clk) begin
    if (m_valid) begin
      for (int d = 0; d < 2; d++) begin
        logic [24:0] act, exp;
        act = {o_rdy[d], o_wen[d], o_addr[d], o_data[d], o_hold[d], o_dn[d], o_er[d]};
        exp = {m_recv[d], m_write[d], m_waddr[d], m_wdata[d], m_busy[d], m_done[d], m_err[d]};
        total++;
        if (act !== exp) begin
          bad++;
          $display("FAIL cycle_cmp dut%0d t=%0t got=%h expected=%h (rdy,wen,addr,data,hold,done,err)",
                   d, $time, act, exp);
        end
        if (o_wen[d] === 1'b1) begin
          wcount[d]++;
          wmem[d][o_addr[d]] = o_data[d];
          if (d == 0) wcyc.push_back(cyc);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_nib(input logic [3:0] n, input int stall);
    bit acc;
    bit got;
    got = 1'b0;
    rx_valid = 1'b0;
    for (int i = 0; i < stall; i++) tick();
    rx_valid = 1'b1;
    RX_NIB   = n;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      acc = o_rdy[0];
      tick();
      got = acc;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL nibble_accept_timeout got=0 expected=1");
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int maxstall, input bit fixed);
    for (int i = 3; i >= 0; i--)
      send_nib(w[4*i +: 4], fixed ? maxstall : int'($urandom_range(0, maxstall)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clr_log();
    for (int d = 0; d < 2; d++) begin
      wcount[d] = 0;
      for (int i = 0; i < 16; i++) wmem[d][i] = '0;
    end
    wcyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b1; rx_valid = 1'b1; RX_NIB = 4'hF;
    wait_cycles(2);
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0;
  endtask

  logic [15:0] w, sx;
  int          nbad_int;

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; RX_NIB = '0;
    clr_log();
    tick();
    do_reset();
    @(negedge clk);
    check("rst_rx_ready", 32'(o_rdy[0]), 0);
    check("rst_wr_en",    32'(o_wen[0]), 0);
    check("rst_wr_addr",  32'(o_addr[0]), 0);
    check("rst_wr_data",  32'(o_data[0]), 0);
    check("rst_cpu_hold", 32'(o_hold[0]), 0);
    check("rst_done",     32'(o_dn[0]), 0);
    check("rst_err",      32'(o_er[0]), 0);
    tick();

    // Full 16-word stream of 0x1234 with rx_valid held high.
    clr_log();
    pulse_start();
    for (int i = 0; i < 16; i++) send_word(16'h1234, 0, 1'b1);
    if (CK) send_word(16'h0000, 0, 1'b1);
    rx_valid = 1'b0;
    wait_cycles(3);
    @(negedge clk);
    check("t1_write_count", 32'(wcount[0]), 16);
    check("t1_pulse_count", 32'(wcyc.size()), 16);
    nbad_int = 0;
    for (int i = 1; i < wcyc.size(); i++) if (wcyc[i] - wcyc[i-1] != 5) nbad_int++;
    check("t1_write_spacing", 32'(nbad_int), 0);
    check("t1_addr0", 32'(wmem[0][0]), 32'h1234);
    check("t1_addr15", 32'(wmem[0][15]), 32'h1234);
    check("t1_done", 32'(o_dn[0]), 1);
    tick();

    // Restart from DONE; stalled 0xA5C3 / 0x0F0F then random words.
    clr_log();
    pulse_start();
    send_word(16'hA5C3, 3, 1'b1);
    send_word(16'h0F0F, 3, 1'b1);
    sx = 16'hA5C3 ^ 16'h0F0F;
    for (int i = 2; i < 16; i++) begin
      w = 16'($urandom);
      sx = sx ^ w;
      send_word(w, 3, 1'b0);
    end
    if (CK) send_word(sx, 2, 1'b0);
    rx_valid = 1'b0;
    wait_cycles(3);
    @(negedge clk);
    check("t2_small_addr0", 32'(wmem[1][0]), 32'hA5C3);
    check("t2_small_addr1", 32'(wmem[1][1]), 32'h0F0F);
    check("t2_small_count", 32'(wcount[1]), 2);
    check("t2_big_addr0", 32'(wmem[0][0]), 32'hA5C3);
    check("t2_big_count", 32'(wcount[0]), 16);
    check("t2_big_done", 32'(o_dn[0]), 1);
    tick();

    // start pulsed mid-session must not disturb the sequence.
    clr_log();
    pulse_start();
    sx = '0;
    for (int i = 0; i < 16; i++) begin
      w = 16'($urandom);
      sx = sx ^ w;
      if (i == 5) begin
        rx_valid = 1'b0;
        wait_cycles(2);
        pulse_start();
      end
      send_word(w, 2, 1'b0);
    end
    if (CK) send_word(sx, 1, 1'b0);
    rx_valid = 1'b0;
    wait_cycles(3);
    @(negedge clk);
    check("t3_count", 32'(wcount[0]), 16);
    check("t3_last_word", 32'(wmem[0][15]), 32'(w));
    tick();

    // Reset after two nibbles of the 4th word.
    clr_log();
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(16'($urandom), 1, 1'b0);
    send_nib(4'h7, 0);
    send_nib(4'h8, 0);
    rx_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t4_hold_after_rst", 32'(o_hold[0]), 0);
    check("t4_addr_after_rst", 32'(o_addr[0]), 0);
    check("t4_ready_after_rst", 32'(o_rdy[0]), 0);
    wait_cycles(4);
    check("t4_write_count", 32'(wcount[0]), 3);

    // rx_valid with 0xF in IDLE is ignored.
    rx_valid = 1'b1; RX_NIB = 4'hF;
    wait_cycles(3);
    @(negedge clk);
    check("t5_idle_ready", 32'(o_rdy[0]), 0);
    tick();
    rx_valid = 1'b0;
    clr_log();
    pulse_start();
    send_word(16'h4321, 1, 1'b1);
    rx_valid = 1'b0;
    wait_cycles(2);
    check("t5_first_word", 32'(wmem[0][0]), 32'h4321);
    check("t5_count", 32'(wcount[0]), 1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum on the 2-word loader: good then bad.
    do_reset();
    pulse_start();
    send_word(16'h00FF, 0, 1'b1);
    send_word(16'h0F00, 0, 1'b1);
    send_word(16'h0FFF, 0, 1'b1);
    rx_valid = 1'b0;
    wait_cycles(2);
    @(negedge clk);
    check("ck_good_done", 32'(o_dn[1]), 1);
    check("ck_good_err", 32'(o_er[1]), 0);
    tick();
    pulse_start();
    send_word(16'h00FF, 0, 1'b1);
    send_word(16'h0F00, 0, 1'b1);
    send_word(16'h0FFE, 0, 1'b1);
    rx_valid = 1'b0;
    wait_cycles(2);
    @(negedge clk);
    check("ck_bad_err", 32'(o_er[1]), 1);
    check("ck_bad_hold", 32'(o_hold[1]), 1);
    check("ck_bad_done", 32'(o_dn[1]), 0);
    tick();
`else
    @(negedge clk);
    check("nock_err_tied", 32'(o_er[1]), 0);
    tick();
`endif

    wait_cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
